// File: rtl/lab3_cache_line_burst_engine_pkg.sv
// Shared message types, line geometry constants and engine state encoding
// for the cache line burst engine.
package lab3_cache_line_burst_engine_pkg;

   localparam int          LINE_WORDS     = 16;
   localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFC0;

   localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
   localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

   typedef struct packed {
      logic [2:0]   type_;
      logic [7:0]   opaque;
      logic [31:0]  addr;
      logic [1:0]   len;
      logic [31:0]  data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]   type_;
      logic [7:0]   opaque;
      logic [1:0]   len;
      logic [31:0]  data;
   } mem_resp_4B_t;

   typedef struct packed {
      logic [2:0]   type_;
      logic [31:0]  addr;
      logic [511:0] data;
   } mem_req_64B_t;

   typedef struct packed {
      logic [2:0]   type_;
      logic [511:0] data;
   } mem_resp_64B_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_RESP
   } engine_state_e;

endpackage

// File: rtl/lab3_cache_line_burst_engine_if.sv
// Cache-side line handshake and memory-side word handshake of the burst engine.
// The slave modport is the engine's view; master is the cache/memory environment.
interface lab3_cache_line_burst_engine_if;
   import lab3_cache_line_burst_engine_pkg::*;

   mem_req_64B_t  cache_req_msg;
   logic          cache_req_val;
   logic          cache_req_rdy;
   mem_resp_64B_t cache_resp_msg;
   logic          cache_resp_val;
   logic          cache_resp_rdy;

   mem_req_4B_t   mem_req_msg;
   logic          mem_req_val;
   logic          mem_req_rdy;
   mem_resp_4B_t  mem_resp_msg;
   logic          mem_resp_val;
   logic          mem_resp_rdy;

   modport slave (
      input  cache_req_msg, cache_req_val, cache_resp_rdy,
      output cache_req_rdy, cache_resp_msg, cache_resp_val,
      output mem_req_msg, mem_req_val, mem_resp_rdy,
      input  mem_req_rdy, mem_resp_msg, mem_resp_val
   );

   modport master (
      output cache_req_msg, cache_req_val, cache_resp_rdy,
      input  cache_req_rdy, cache_resp_msg, cache_resp_val,
      input  mem_req_msg, mem_req_val, mem_resp_rdy,
      output mem_req_rdy, mem_resp_msg, mem_resp_val
   );

endinterface

// File: rtl/lab3_cache_word_counter.sv
// Word index counter for one direction of a line transfer; one extra bit
// lets the count reach p_num_words so done can be flagged without wrapping.
module lab3_cache_word_counter #(
   parameter int p_num_words = 16,
   parameter int p_cnt_bits  = $clog2(p_num_words) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  inc,
   output logic [p_cnt_bits-1:0] cnt,
   output logic                  done
);

   logic [p_cnt_bits-1:0] cnt_reg;
   logic [p_cnt_bits-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr)
         cnt_next = '0;
      else if (inc)
         cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   assign cnt  = cnt_reg;
   assign done = (cnt_reg == p_cnt_bits'(p_num_words));

endmodule

// File: rtl/lab3_cache_line_burst_engine.sv
// Line transfer engine: one 64B line request becomes a burst of 4B memory
// requests whose in-order responses are folded back into one line response.
module lab3_cache_line_burst_engine
   import lab3_cache_line_burst_engine_pkg::*;
#(
   parameter int p_num_words  = LINE_WORDS,
   parameter int p_line_bytes = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   lab3_cache_line_burst_engine_if.slave  bus,
   output logic                           xfer_err
);

   localparam int          CW        = $clog2(p_num_words) + 1;
   localparam logic [31:0] ADDR_MASK = ~(32'(p_line_bytes) - 32'd1);

   engine_state_e             state_reg;
   engine_state_e             state_next;
   logic [2:0]                type_reg;
   logic [31:0]               base_reg;
   logic                      xfer_err_reg;
   logic                      load_line;
   logic                      req_fire;
   logic                      resp_fire;
   logic                      is_write;
   logic [CW-1:0]             send_cnt;
   logic [CW-1:0]             recv_cnt;
   logic                      send_done;
   logic                      recv_done;
   logic [CW-2:0]             send_idx;
   logic [p_num_words*32-1:0] line_data;
   logic                      unused_resp_bits;

   assign req_fire  = bus.mem_req_val && bus.mem_req_rdy;
   assign resp_fire = bus.mem_resp_val && bus.mem_resp_rdy;
   assign is_write  = (type_reg == MEM_TYPE_WRITE);
   assign send_idx  = send_cnt[CW-2:0];
   assign xfer_err  = xfer_err_reg;

   assign unused_resp_bits = ^{bus.mem_resp_msg.type_, bus.mem_resp_msg.len};

   lab3_cache_word_counter #(.p_num_words(p_num_words), .p_cnt_bits(CW)) u_send_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (load_line),
      .inc   (req_fire),
      .cnt   (send_cnt),
      .done  (send_done)
   );

   lab3_cache_word_counter #(.p_num_words(p_num_words), .p_cnt_bits(CW)) u_recv_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (load_line),
      .inc   (resp_fire),
      .cnt   (recv_cnt),
      .done  (recv_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         type_reg     <= MEM_TYPE_READ;
         base_reg     <= '0;
         xfer_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (load_line) begin
            type_reg <= bus.cache_req_msg.type_;
            base_reg <= bus.cache_req_msg.addr & ADDR_MASK;
         end
         if (resp_fire && (bus.mem_resp_msg.opaque != 8'(recv_cnt)))
            xfer_err_reg <= 1'b1;
      end
   end

   // Issue and collection run concurrently in XFER; the last response alone decides the exit.
   always_comb begin
      state_next         = state_reg;
      load_line          = 1'b0;
      bus.cache_req_rdy  = 1'b0;
      bus.cache_resp_val = 1'b0;
      bus.mem_req_val    = 1'b0;
      bus.mem_resp_rdy   = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            bus.cache_req_rdy = reset;
            if (bus.cache_req_val && reset) begin
               load_line  = 1'b1;
               state_next = ST_XFER;
            end
         end
         ST_XFER: begin
            bus.mem_req_val  = !send_done;
            bus.mem_resp_rdy = !recv_done;
            if (bus.mem_resp_val && !recv_done && (recv_cnt == CW'(p_num_words - 1)))
               state_next = ST_RESP;
         end
         ST_RESP: begin
            bus.cache_resp_val = 1'b1;
            if (bus.cache_resp_rdy)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req_msg        = '0;
      bus.mem_req_msg.type_  = type_reg;
      bus.mem_req_msg.opaque = 8'(send_cnt);
      bus.mem_req_msg.addr   = base_reg + 32'({send_cnt, 2'b00});
      bus.mem_req_msg.len    = 2'd0;
      bus.mem_req_msg.data   = is_write ? line_data[{send_idx, 5'b00000} +: 32] : 32'h0;

      bus.cache_resp_msg       = '0;
      bus.cache_resp_msg.type_ = type_reg;
      bus.cache_resp_msg.data  = is_write ? '0 : line_data;
   end

   // Line buffer holds the outgoing write line, then is overwritten word by word on a refill.
   genvar gi;
   generate
      for (gi = 0; gi < p_num_words; gi++) begin : g_word
         logic [31:0] word_reg;
         logic        word_we;

         assign word_we = resp_fire && !is_write && (recv_cnt == CW'(gi));

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               word_reg <= '0;
            else if (load_line)
               word_reg <= bus.cache_req_msg.data[32*gi +: 32];
            else if (word_we)
               word_reg <= bus.mem_resp_msg.data;
         end

         assign line_data[32*gi +: 32] = word_reg;
      end
   endgenerate

endmodule

// File: tb/tb_lab3_cache_line_burst_engine.sv
// Scoreboard bench for the line burst engine: a small memory model answers word
// requests, and expected word requests and line responses are queued at issue.
module tb_lab3_cache_line_burst_engine;
   import lab3_cache_line_burst_engine_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic xfer_err;

   lab3_cache_line_burst_engine_if bif();

   lab3_cache_line_burst_engine #(.p_num_words(16), .p_line_bytes(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bif),
      .xfer_err (xfer_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      mem_resp_4B_t msg;
      int           due;
   } pend_t;

   mem_req_4B_t   exp_req_q[$];
   mem_resp_64B_t exp_line_q[$];
   pend_t         pend_q[$];

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;

   int resp_delay = 1;
   bit rdy_toggle = 1'b0;
   int bad_op_idx = -1;
   int hold_left  = 0;
   bit probe_req  = 1'b0;

   logic [31:0]  mem_data [16];
   bit           creq_pending = 1'b0;
   mem_req_64B_t creq_msg;

   int n_req, n_resp, n_acc, acc_cyc, first_val_cyc, resp_fire_cyc;
   bit line_done;

   task automatic check_val(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      chk_cnt++;
      if (obs === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: drive inputs at negedge, then observe what fires on the coming posedge.
   task automatic step();
      @(negedge clk);
      cyc++;
      bif.mem_req_rdy = rdy_toggle ? cyc[0] : 1'b1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         bif.mem_resp_val = 1'b1;
         bif.mem_resp_msg = pend_q[0].msg;
      end else begin
         bif.mem_resp_val = 1'b0;
         bif.mem_resp_msg = '0;
      end
      if (hold_left > 0 && bif.cache_resp_val) begin
         hold_left--;
         bif.cache_resp_rdy      = 1'b0;
         bif.cache_req_val       = probe_req;
         bif.cache_req_msg       = '0;
         bif.cache_req_msg.addr  = 32'h80;
      end else begin
         bif.cache_resp_rdy = 1'b1;
         bif.cache_req_val  = creq_pending;
         bif.cache_req_msg  = creq_msg;
      end
      #1;
      if (!bif.cache_resp_rdy && bif.cache_req_val)
         check_val("req_rdy_in_resp", bif.cache_req_rdy, 1'b0);
      if (bif.cache_req_val && bif.cache_req_rdy) begin
         n_acc++;
         acc_cyc      = cyc;
         creq_pending = 1'b0;
      end
      if (bif.mem_resp_val && bif.mem_resp_rdy) begin
         pend_q.pop_front();
         n_resp++;
      end
      if (bif.mem_req_val) begin
         if (exp_req_q.size() == 0) begin
            check_val("mreq_extra", 1, 0);
         end else begin
            check_val($sformatf("mreq_%0d", n_req), bif.mem_req_msg, exp_req_q[0]);
            if (bif.mem_req_rdy) begin
               mem_resp_4B_t r;
               pend_t        p;
               r.type_  = exp_req_q[0].type_;
               r.opaque = (int'(exp_req_q[0].opaque) == bad_op_idx) ? 8'd9 : exp_req_q[0].opaque;
               r.len    = 2'd0;
               r.data   = (exp_req_q[0].type_ == MEM_TYPE_WRITE) ? 32'h0 : mem_data[exp_req_q[0].opaque[3:0]];
               p.msg    = r;
               p.due    = cyc + resp_delay;
               pend_q.push_back(p);
               exp_req_q.pop_front();
               n_req++;
            end
         end
      end
      if (bif.cache_resp_val) begin
         if (first_val_cyc < 0)
            first_val_cyc = cyc;
         if (exp_line_q.size() == 0) begin
            check_val("cresp_extra", 1, 0);
         end else begin
            check_val("cresp_msg", bif.cache_resp_msg, exp_line_q[0]);
            if (bif.cache_resp_rdy) begin
               exp_line_q.pop_front();
               resp_fire_cyc = cyc;
               line_done     = 1'b1;
            end
         end
      end
   endtask

   task automatic send_line(input logic [2:0] t, input logic [31:0] addr, input logic [511:0] data);
      mem_resp_64B_t el;
      logic [31:0]   base;
      base = addr & LINE_ADDR_MASK;
      for (int i = 0; i < 16; i++) begin
         mem_req_4B_t q;
         q.type_  = t;
         q.opaque = 8'(i);
         q.addr   = base + 32'(4 * i);
         q.len    = 2'd0;
         q.data   = (t == MEM_TYPE_WRITE) ? data[32*i +: 32] : 32'h0;
         exp_req_q.push_back(q);
      end
      el.type_ = t;
      for (int i = 0; i < 16; i++)
         el.data[32*i +: 32] = (t == MEM_TYPE_WRITE) ? 32'h0 : mem_data[i];
      exp_line_q.push_back(el);
      creq_msg.type_ = t;
      creq_msg.addr  = addr;
      creq_msg.data  = data;
      creq_pending   = 1'b1;
      n_req = 0; n_resp = 0; n_acc = 0;
      acc_cyc = -1; first_val_cyc = -1; resp_fire_cyc = -1;
      line_done = 1'b0;
   endtask

   task automatic run_line(input int budget);
      int k;
      k = 0;
      while (!line_done && k < budget) begin
         step();
         k++;
      end
      if (!line_done)
         check_val("line_timeout", 0, 1);
   endtask

   initial begin
      logic [511:0] wdata;
      reset              = 1'b0;
      bif.cache_req_val  = 1'b0;
      bif.cache_req_msg  = '0;
      bif.cache_resp_rdy = 1'b1;
      bif.mem_req_rdy    = 1'b1;
      bif.mem_resp_val   = 1'b0;
      bif.mem_resp_msg   = '0;
      creq_msg           = '0;
      for (int i = 0; i < 16; i++)
         mem_data[i] = 32'hA0 + 32'(i);

      repeat (2) @(negedge clk);
      #1;
      check_val("rst_creq_rdy", bif.cache_req_rdy, 1'b0);
      check_val("rst_mreq_val", bif.mem_req_val, 1'b0);
      check_val("rst_mresp_rdy", bif.mem_resp_rdy, 1'b0);
      check_val("rst_cresp_val", bif.cache_resp_val, 1'b0);
      check_val("rst_xfer_err", xfer_err, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("idle_creq_rdy", bif.cache_req_rdy, 1'b1);

      // Read refill, zero-wait memory
      send_line(MEM_TYPE_READ, 32'h0000_1234, '0);
      run_line(60);
      check_val("t1_nreq", n_req, 16);
      check_val("t1_nresp", n_resp, 16);
      check_val("t1_latency", first_val_cyc - acc_cyc, 18);
      check_val("t1_xfer_err", xfer_err, 1'b0);

      // Eviction write
      for (int i = 0; i < 16; i++)
         wdata[32*i +: 32] = 32'h1000 + 32'(i);
      send_line(MEM_TYPE_WRITE, 32'h0000_0840, wdata);
      run_line(60);
      check_val("t2_nreq", n_req, 16);
      check_val("t2_nresp", n_resp, 16);

      // Stalling memory: request ready toggles, responses 3 cycles late
      rdy_toggle = 1'b1;
      resp_delay = 3;
      for (int i = 0; i < 16; i++)
         mem_data[i] = 32'h5500 + 32'(3 * i);
      send_line(MEM_TYPE_READ, 32'h0000_2008, '0);
      run_line(200);
      check_val("t3_nreq", n_req, 16);
      check_val("t3_nresp", n_resp, 16);
      rdy_toggle = 1'b0;
      resp_delay = 1;

      // Cache back-pressure in RESP with a competing line request
      hold_left = 5;
      probe_req = 1'b1;
      send_line(MEM_TYPE_READ, 32'h0000_3010, '0);
      run_line(80);
      check_val("t4_hold_cycles", resp_fire_cyc - first_val_cyc, 5);
      check_val("t4_accepts", n_acc, 1);
      probe_req = 1'b0;

      // Bad opaque on word 7
      bad_op_idx = 7;
      send_line(MEM_TYPE_READ, 32'h0000_4000, '0);
      run_line(60);
      check_val("t5_xfer_err", xfer_err, 1'b1);
      bad_op_idx = -1;
      step();
      step();
      check_val("t5_xfer_err_sticky", xfer_err, 1'b1);

      // Reset in the middle of a line
      resp_delay = 3;
      send_line(MEM_TYPE_READ, 32'h0000_5000, '0);
      for (int k = 0; k < 40 && n_req < 8; k++)
         step();
      check_val("t6_nreq", n_req, 8);
      check_val("t6_nresp", n_resp, 5);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_val("t6_rst_mreq_val", bif.mem_req_val, 1'b0);
      check_val("t6_rst_mresp_rdy", bif.mem_resp_rdy, 1'b0);
      check_val("t6_rst_cresp_val", bif.cache_resp_val, 1'b0);
      check_val("t6_rst_creq_rdy", bif.cache_req_rdy, 1'b0);
      check_val("t6_rst_xfer_err", xfer_err, 1'b0);
      exp_req_q.delete();
      exp_line_q.delete();
      pend_q.delete();
      creq_pending = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;
      check_val("t6_rel_creq_rdy", bif.cache_req_rdy, 1'b1);
      resp_delay = 1;
      for (int i = 0; i < 16; i++)
         mem_data[i] = 32'hC000 + 32'(i);
      send_line(MEM_TYPE_READ, 32'h0000_0040, '0);
      run_line(60);
      check_val("t6_nreq", n_req, 16);
      check_val("t6_nresp", n_resp, 16);
      check_val("t6_xfer_err", xfer_err, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
